// File: rtl/cv32e41p_bitcnt_seq.sv
// cv32e41p_bitcnt_seq: multi-cycle popcnt/ctz/clz that folds CHUNK bits per cycle.
// Define CV32E41P_BITCNT_EARLY_EXIT_EN to end ctz/clz after the first chunk that holds a one.
module cv32e41p_bitcnt_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0]                 op_i,
    input  logic [WIDTH-1:0]           operand_i,
    input  logic                       kill_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(WIDTH):0]     result_o
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned RW = $clog2(WIDTH) + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, operand_rev;
    logic [RW-1:0]    acc_q, acc_d, ones, tz;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tz_q, tz_d, found_q, found_d, accept, last;
    logic [CHUNK-1:0] chunk;

    assign in_ready_o  = (state_q == IDLE) & ~kill_i;
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = state_q == DONE;
    assign result_o    = acc_q;
    assign chunk       = shift_q[CHUNK-1:0];

    // clz is folded onto ctz by reversing the operand at accept.
    always_comb begin
        operand_rev = '0;
        for (int i = 0; i < WIDTH; i++) operand_rev[i] = operand_i[WIDTH-1-i];
        ones = '0;
        tz   = RW'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            ones = ones + RW'(chunk[i]);
            if (chunk[i]) tz = RW'(i);
        end
    end

`ifdef CV32E41P_BITCNT_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(N - 1)) | (tz_q & ~found_q & (|chunk));
`else
    assign last = cnt_q == CW'(N - 1);
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tz_d    = tz_q;
        found_d = found_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = BUSY;
                shift_d = (op_i == 2'b10) ? operand_rev : operand_i;
                tz_d    = ^op_i;
                acc_d   = '0;
                cnt_d   = '0;
                found_d = 1'b0;
            end
            BUSY: begin
                acc_d   = acc_q + (tz_q ? (found_q ? {RW{1'b0}} : tz) : ones);
                found_d = found_q | (|chunk);
                shift_d = shift_q >> CHUNK;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? DONE : BUSY;
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tz_q    <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tz_q    <= tz_d;
            found_q <= found_d;
        end
    end
endmodule

// File: tb/tb_cv32e41p_bitcnt_seq.sv
// tb_cv32e41p_bitcnt_seq: directed and random checks of cv32e41p_bitcnt_seq against a reference model.
module tb_cv32e41p_bitcnt_seq;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int N  = W / C;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          kill_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic [W-1:0]  operand_i = '0;
    logic          in_ready_o, out_valid_o;
    logic [RW-1:0] result_o;
    int            tests = 0;
    int            fails = 0;

    cv32e41p_bitcnt_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .operand_i(operand_i), .kill_i(kill_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_count(input logic [1:0] op, input logic [W-1:0] x);
        if (op == 2'b01) begin
            for (int i = 0; i < W; i++) if (x[i]) return i;
            return W;
        end
        if (op == 2'b10) begin
            for (int i = 0; i < W; i++) if (x[W-1-i]) return i;
            return W;
        end
        return $countones(x);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] x);
        ref_lat = N;
`ifdef CV32E41P_BITCNT_EARLY_EXIT_EN
        if ((op == 2'b01 || op == 2'b10) && ref_count(op, x) < W) ref_lat = ref_count(op, x) / C + 1;
`endif
    endfunction

    task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] x);
        chk({tag, "_ready"}, {31'b0, in_ready_o}, 32'd1);
        in_valid_i = 1'b1;
        op_i       = op;
        operand_i  = x;
        @(negedge clk);
        in_valid_i = 1'b0;
        op_i       = 2'($urandom);
        operand_i  = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] x);
        int lat;
        issue(tag, op, x);
        wait_done(lat);
        chk({tag, "_lat"}, lat, ref_lat(op, x));
        chk({tag, "_res"}, {26'b0, result_o}, ref_count(op, x));
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk({tag, "_vld_drop"}, {31'b0, out_valid_o}, 32'd0);
        chk({tag, "_idle"}, {31'b0, in_ready_o}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [1:0] op;
        logic [W-1:0] x;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", {31'b0, out_valid_o}, 32'd0);
        chk("rst_res", {26'b0, result_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready_o}, 32'd1);

        run("pop_ones", 2'b00, 32'hFFFF_FFFF);
        run("pop_zero", 2'b00, 32'h0000_0000);
        run("pop_ends", 2'b00, 32'h8000_0001);
        run("ctz_100", 2'b01, 32'h0000_0100);
        run("ctz_msb", 2'b01, 32'h8000_0000);
        run("clz_10000", 2'b10, 32'h0001_0000);
        run("clz_zero", 2'b10, 32'h0000_0000);
        run("clz_ones", 2'b10, 32'hFFFF_FFFF);
        run("ctz_zero", 2'b01, 32'h0000_0000);
        run("pop_op3", 2'b11, 32'h0F0F_0001);

        // back-pressure: a pending request must not disturb the held result
        issue("bp", 2'b00, 32'hF0F0_F0F0);
        wait_done(lat);
        chk("bp_lat", lat, N);
        in_valid_i = 1'b1;
        op_i       = 2'b00;
        operand_i  = 32'h0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld", {31'b0, out_valid_o}, 32'd1);
            chk("bp_res", {26'b0, result_o}, 32'd16);
            chk("bp_ready", {31'b0, in_ready_o}, 32'd0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("bp_back_idle", {31'b0, in_ready_o}, 32'd1);
        run("bp_next", 2'b01, 32'h0000_0040);

        // kill during BUSY
        issue("kbusy", 2'b00, 32'hFFFF_FFFF);
        @(negedge clk);
        kill_i = 1'b1;
        #1 chk("kill_comb_ready", {31'b0, in_ready_o}, 32'd0);
        @(negedge clk);
        kill_i = 1'b0;
        #1 chk("kbusy_idle", {31'b0, in_ready_o}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("kbusy_no_vld", {31'b0, out_valid_o}, 32'd0);
        end

        // kill with a request in IDLE: no accept
        in_valid_i = 1'b1;
        kill_i     = 1'b1;
        op_i       = 2'b00;
        operand_i  = 32'hFF;
        #1 chk("kidle_ready", {31'b0, in_ready_o}, 32'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        kill_i     = 1'b0;
        #1 chk("kidle_no_accept", {31'b0, in_ready_o}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("kidle_no_vld", {31'b0, out_valid_o}, 32'd0);
        end

        // kill in DONE
        issue("kdone", 2'b00, 32'h3);
        wait_done(lat);
        chk("kdone_vld", {31'b0, out_valid_o}, 32'd1);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("kdone_drop", {31'b0, out_valid_o}, 32'd0);
        #1 chk("kdone_idle", {31'b0, in_ready_o}, 32'd1);
        @(negedge clk);

        // asynchronous reset mid-BUSY
        issue("rbusy", 2'b00, 32'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rbusy_vld", {31'b0, out_valid_o}, 32'd0);
        chk("rbusy_res", {26'b0, result_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("after_rst", 2'b00, 32'h0000_000F);

        repeat (30) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: x = $urandom;
                1: x = $urandom & $urandom & $urandom;
                default: x = 32'h1 << $urandom_range(0, 31);
            endcase
            run("rand", op, x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
